// File: rtl/psum_out_drain.sv
// psum_out_drain
//   Output-path drain stage. Buffers whole psum rows arriving on a valid-only
//   strobe (no backpressure) in a small row FIFO and serializes the head row
//   onto a narrow valid/ready bus, lower lanes first. A row arriving while the
//   FIFO has no room is dropped and the sticky overflow flag is raised.
//
//   Build option: define PSUM_DRAIN_RELU_EN to clamp negative lanes to zero at
//   the output mux. Stored rows stay raw and no latency is added.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   row strobe from the core
//   in_data    psum row, lane 0 in bits [psum_bw-1:0]
//   out_ready  consumer accepts the current beat
//   out_valid  a beat is present (FIFO not empty)
//   out_data   current beat, lower lane index in lower bits
//   out_last   current beat is the final beat of its row
//   count      rows stored, including the row being drained
//   overflow   sticky: at least one row was dropped since reset

module psum_out_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = 32,
    parameter int depth   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [psum_bw*col-1:0]       in_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [out_bw-1:0]            out_data,
    output logic                         out_last,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         overflow
);

    localparam int ROW_W = psum_bw * col;
    localparam int BPR   = ROW_W / out_bw;
    localparam int LPB   = out_bw / psum_bw;
    localparam int PW    = $clog2(depth);
    localparam int CW    = $clog2(depth + 1);
    localparam int BIW   = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [CW-1:0]  DEPTH_C   = CW'(depth);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BPR - 1);

    logic [ROW_W-1:0]  mem [depth];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [BIW-1:0]    beat_idx;

    logic [ROW_W-1:0]  head_row;
    logic [out_bw-1:0] raw_beat;
    logic [out_bw-1:0] beat_mux;
    logic              xfer;
    logic              pop;
    logic              room;
    logic              wr_en;

    // Output mux: head row slice selected by beat_idx. Gated to zero when
    // empty so never-written storage does not leak onto out_data.
    always_comb begin
        out_valid = (count != '0);
        head_row  = mem[rd_ptr];
        raw_beat  = head_row[int'(beat_idx)*out_bw +: out_bw];
        beat_mux  = raw_beat;
`ifdef PSUM_DRAIN_RELU_EN
        for (int unsigned l = 0; l < LPB; l++) begin
            if (raw_beat[int'(l)*psum_bw + psum_bw - 1]) begin
                beat_mux[int'(l)*psum_bw +: psum_bw] = '0;
            end
        end
`endif
        out_data  = out_valid ? beat_mux : '0;
        out_last  = out_valid && (beat_idx == LAST_BEAT);
    end

    // A full FIFO still accepts a row when its head row pops in the same
    // cycle; the new row lands in the slot being vacated.
    always_comb begin
        xfer  = out_valid && out_ready;
        pop   = xfer && (beat_idx == LAST_BEAT);
        room  = (count != DEPTH_C) || pop;
        wr_en = in_valid && room;
    end

    // Row storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_idx <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (in_valid && !room) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                if (pop) begin
                    beat_idx <= '0;
                    rd_ptr   <= rd_ptr + PW'(1);
                end else begin
                    beat_idx <= beat_idx + BIW'(1);
                end
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/psum_out_drain.md
Name: psum_out_drain

Overview:
- Downstream stage of the core's output path.
- Captures each valid wide psum row (col lanes × psum_bw) into a small row FIFO.
- Serializes buffered rows onto a narrow valid/ready bus for the host/testbench readout port.
- Decouples the core's valid-only output, which has no backpressure, from a slower consumer. Detects and flags dropped rows.

Parameters:
- col, 8, number of psum lanes per row
- psum_bw, 16, bits per psum lane (two's complement)
- out_bw, 32, output beat width; must be a multiple of psum_bw and divide col*psum_bw
- depth, 4, FIFO depth in rows; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  row strobe from core valid
- in_data  input  psum_bw*col  row from core output; lane 0 = bits [psum_bw-1:0]
- out_ready  input  1  consumer accepts beat
- out_valid  output  1  beat present
- out_data  output  out_bw  current beat; lower lane index in lower bits
- out_last  output  1  final beat of a row
- count  output  $clog2(depth+1)  rows currently stored (including row being drained)
- overflow  output  1  sticky: a row was dropped

Behaviour:
- Definitions:
  - BPR = col*psum_bw/out_bw beats per row (default 4).
  - LPB = out_bw/psum_bw lanes per beat (default 2).
- Reset (reset=0, async):
  - wr_ptr, rd_ptr, beat_idx, count = 0.
  - out_valid = 0, out_last = 0, out_data = 0, overflow = 0.
  - FIFO storage is not cleared.
  - Reset mid-row discards all stored rows and any partial beat progress.
- Write:
  - On a clk edge with in_valid=1 and room, store in_data at wr_ptr and advance wr_ptr (wraps mod depth).
  - Room means count<depth, OR count==depth with the final beat of the head row handshaking in the same cycle.
  - Otherwise the row is dropped and overflow is set to 1; overflow stays 1 until reset.
- Read/serialize:
  - out_valid = (count != 0).
  - out_data = lanes [beat_idx*LPB .. beat_idx*LPB+LPB-1] of the row at rd_ptr, driven combinationally from FIFO storage and beat_idx.
  - out_last = out_valid && beat_idx==BPR-1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - out_data and out_last must stay stable while out_valid && !out_ready.
  - On a transfer with beat_idx<BPR-1: beat_idx++.
  - On a transfer with beat_idx==BPR-1: beat_idx=0, rd_ptr advances (wraps), and the row is popped.
- count:
  - +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
  - Updated registered; never exceeds depth and never underflows.
- Empty:
  - A write into an empty FIFO makes out_valid=1 on the next cycle; there is no same-cycle bypass.
  - Minimum in→out latency is 1 cycle.
- Throughput:
  - One beat per cycle while out_ready=1.
  - Sustained rows every BPR cycles without loss.
- States (implicit in count/beat_idx):
  - EMPTY (count=0)
  - DRAIN (count>0)
  - FULL (count=depth); FULL still drains.
- in_data is sampled only on accepted writes; X on in_data while in_valid=0 must not propagate.

Optional Feature:
- Macro: PSUM_DRAIN_RELU_EN.
- Defined: each lane is clamped at the output mux. A lane with MSB=1 (negative) is replaced by 0; non-negative lanes pass unchanged. Stored rows remain raw, and clamping adds no latency.
- Undefined: lanes pass through unmodified.
- Handshake, count and overflow behaviour are identical in both builds.

Test Plan:
- Single row:
  - Stimulus: reset, then in_valid for 1 cycle with lanes 0..7 = 0x0001..0x0008; out_ready=1.
  - Response: next cycle count=1, out_valid=1. Beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 on 4 consecutive cycles, out_last on the 4th only, then count=0 and out_valid=0.
- Backpressure:
  - Stimulus: same row, out_ready=0 for 5 cycles, then 1.
  - Response: out_data stays 0x00020001 and out_valid stays 1 throughout the stall; all 4 beats follow in order; overflow=0.
- Fill and overflow:
  - Stimulus: out_ready=0; 5 consecutive rows with lane0 = 1..5.
  - Response: count=4, overflow=1. Draining yields rows 1,2,3,4 only; overflow stays 1.
- Write on pop while full:
  - Stimulus: FIFO full, out_ready=1; a new row (lane0=9) arrives exactly in the cycle out_last handshakes.
  - Response: row accepted, count stays 4, overflow=0, row 9 drained last.
- Pointer wrap:
  - Stimulus: stream 10 rows at one row per 4 cycles with out_ready=1.
  - Response: all 40 beats in order, count ≤1, overflow=0.
- Reset mid-row:
  - Stimulus: assert reset low after beat 2 of a row.
  - Response: out_valid=0 and count=0 immediately (async). After release, the next row starts at beat 0.
- RELU build:
  - Stimulus: build with PSUM_DRAIN_RELU_EN; lanes 0..1 = 0xFFF0, 0x0010.
  - Response: first beat = 0x00100000.
